// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Branch resolution and prediction for the pipelined core.
//   - Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU in EX from the ALU flags.
//   - Direct-mapped table of 2**IDX_W saturating counters, indexed by
//     pc[IDX_W+1:2], gives a zero-latency taken prediction at fetch.
//   - Registered one-cycle flush pulse when the resolved outcome disagrees
//     with the prediction carried down from fetch.
//
// Optional feature: define BPU_STATS_EN to build the br_cnt/mis_cnt
// statistics counters. Undefined, both outputs are tied to zero.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   f_pc            fetch PC to predict
//   f_pred_taken    prediction for f_pc (combinational)
//   ex_valid        EX stage holds a valid instruction
//   ex_branch       EX instruction is a conditional branch
//   ex_func3        branch condition code
//   ex_zero/neg/ltu ALU flags: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
//   ex_pc           PC of the EX branch (selects the entry to train)
//   ex_pred_taken   prediction made for this branch at fetch
//   ex_taken        resolved outcome (combinational)
//   flush           registered mispredict pulse
//   br_cnt, mis_cnt resolved-branch / mispredict counters
// ---------------------------------------------------------------------------

// One saturating counter of the prediction table.
module bpu_ctr_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);
  // Weakly not-taken: just below the taken threshold.
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (upd_i) begin
      if (taken_i) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_RST;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module branch_predict_unit #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_func3,
  input  logic              ex_zero,
  input  logic              ex_neg,
  input  logic              ex_ltu,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              flush,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);
  localparam int DEPTH = 2 ** IDX_W;

  logic                        res;
  logic [IDX_W-1:0]            f_idx, ex_idx;
  logic [DEPTH-1:0]            upd;
  logic [DEPTH-1:0][CNT_W-1:0] cnt;
  logic                        flush_q, flush_d;

  assign res    = ex_valid & ex_branch;
  // Byte offset bits are dropped so consecutive words hit consecutive entries.
  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Bits of the PCs that never reach the index.
  logic unused_pc;
  assign unused_pc = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                       ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  // ---- resolve ----------------------------------------------------------
  always_comb begin
    ex_taken = 1'b0;
    if (res) begin
      unique case (ex_func3)
        3'b000:  ex_taken = ex_zero;
        3'b001:  ex_taken = ~ex_zero;
        3'b100:  ex_taken = ex_neg;
        3'b101:  ex_taken = ~ex_neg;
        3'b110:  ex_taken = ex_ltu;
        3'b111:  ex_taken = ~ex_ltu;
        default: ex_taken = 1'b0;  // illegal codes resolve (and train) not-taken
      endcase
    end
  end

  // ---- prediction table ---------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign upd[i] = res && (ex_idx == IDX_W'(i));
    bpu_ctr_entry #(.CNT_W(CNT_W)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd_i   (upd[i]),
      .taken_i (ex_taken),
      .cnt_o   (cnt[i])
    );
  end

  // Reads the registered counter, so a same-cycle update is not visible.
  assign f_pred_taken = cnt[f_idx][CNT_W-1];

  // ---- mispredict flush ---------------------------------------------------
  assign flush_d = res & (ex_taken != ex_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_q <= 1'b0;
    else        flush_q <= flush_d;
  end

  assign flush = flush_q;

  // ---- statistics -------------------------------------------------------
`ifdef BPU_STATS_EN
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Free-running, wraps modulo 2**STAT_W.
  assign br_cnt_d  = br_cnt_q  + STAT_W'(res);
  assign mis_cnt_d = mis_cnt_q + STAT_W'(flush_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  assign br_cnt  = '0;
  assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int PC_W   = 32;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   f_pc;
  logic              f_pred_taken;
  logic              ex_valid, ex_branch;
  logic [2:0]        ex_func3;
  logic              ex_zero, ex_neg, ex_ltu;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_pred_taken;
  logic              ex_taken;
  logic              flush;
  logic [STAT_W-1:0] br_cnt, mis_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(4), .CNT_W(2), .STAT_W(STAT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_pc          (f_pc),
    .f_pred_taken  (f_pred_taken),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_func3      (ex_func3),
    .ex_zero       (ex_zero),
    .ex_neg        (ex_neg),
    .ex_ltu        (ex_ltu),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_taken      (ex_taken),
    .flush         (flush),
    .br_cnt        (br_cnt),
    .mis_cnt       (mis_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one EX slot; inputs change 1 time unit after a rising edge.
  task automatic drive(input logic v, input logic b, input logic [2:0] f3,
                       input logic z, input logic n, input logic l,
                       input logic [31:0] pc, input logic pred);
    ex_valid = v; ex_branch = b; ex_func3 = f3;
    ex_zero = z; ex_neg = n; ex_ltu = l;
    ex_pc = pc; ex_pred_taken = pred;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc; #1;
    chk(tag, {31'd0, f_pred_taken}, {31'd0, exp});
  endtask

  task automatic reset_all_zero(input string tag);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_br"},  {16'd0, br_cnt},  32'd0);
    chk({tag, "_mis"}, {16'd0, mis_cnt}, 32'd0);
    for (int i = 0; i < 16; i++) pred_at($sformatf("%s_pred%0d", tag, i), i * 4, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0; #1;
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // zero/neg/ltu = 1/0/1 condition table
  logic [2:0] cf3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic       cexp[7] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};

  initial begin
    rst_n = 1'b0;
    f_pc  = '0;
    idle();
    #3;
    // ---- reset state ----
    reset_all_zero("rst0");
    tick();
    rst_n = 1'b1;
    tick();

    // ---- conditions (pred=0, so flush mirrors the outcome) ----
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, cf3[i], 1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      #1 chk($sformatf("cond_f3_%0d", cf3[i]), {31'd0, ex_taken}, {31'd0, cexp[i]});
      tick();
      chk($sformatf("cond_flush_%0d", cf3[i]), {31'd0, flush}, {31'd0, cexp[i]});
    end
    // not a branch / not valid: outcome 0, flush clears
    drive(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1);
    #1 chk("nobr_taken", {31'd0, ex_taken}, 32'd0);
    tick();
    chk("nobr_flush", {31'd0, flush}, 32'd0);
    drive(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1);
    #1 chk("inv_taken", {31'd0, ex_taken}, 32'd0);
    tick();
    chk("inv_flush", {31'd0, flush}, 32'd0);
    do_reset();

    // ---- training at 0x40 (idx 0): 01 -> 10 -> 11 ----
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0);
    tick();
    chk("train_flush1", {31'd0, flush}, 32'd1);
    tick();
    chk("train_flush2", {31'd0, flush}, 32'd1);
    idle();
    pred_at("train_pred40", 32'h40, 1'b1);
    pred_at("train_pred44", 32'h44, 1'b0);

    // ---- asynchronous reset mid-cycle, while flush is high ----
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0; #1;
    reset_all_zero("rst1");
    tick();
    rst_n = 1'b1;
    tick();

    // ---- saturation at idx 3 (pc 0x0C) ----
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b1);  // 11 -> 10
    tick();
    idle();
    pred_at("sat_hi_pred", 32'h0C, 1'b1);
    for (int i = 0; i < 4; i++) begin                             // 10 -> 00
      drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b0);
      tick();
    end
    idle();
    pred_at("sat_lo_pred", 32'h0C, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);   // 00 -> 01
    tick();
    idle();
    pred_at("sat_nowrap1", 32'h0C, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);   // 01 -> 10
    tick();
    idle();
    pred_at("sat_nowrap2", 32'h0C, 1'b1);
    do_reset();

    // ---- same-cycle read and update of entry 2 ----
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h08, 1'b0);
    pred_at("coll_same", 32'h08, 1'b0);
    tick();
    idle();
    pred_at("coll_next", 32'h08, 1'b1);
    do_reset();

    // ---- statistics: 10 branches, 3 mispredicts (i=2,5,8) ----
    for (int i = 0; i < 10; i++) begin
      logic t, mp;
      t  = i[0];
      mp = (i == 2) || (i == 5) || (i == 8);
      drive(1'b1, 1'b1, 3'b000, t, 1'b0, 1'b0, i * 4, t ^ mp);
      tick();
      chk($sformatf("stat_flush%0d", i), {31'd0, flush}, {31'd0, mp});
      if (i == 4) begin
        drive(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
      end
    end
    idle();
    tick();
`ifdef BPU_STATS_EN
    chk("stat_br",  {16'd0, br_cnt},  32'd10);
    chk("stat_mis", {16'd0, mis_cnt}, 32'd3);
`else
    chk("stat_br_off",  {16'd0, br_cnt},  32'd0);
    chk("stat_mis_off", {16'd0, mis_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
